pipeline_dmem_responder: RTL and testbench



---
 rtl/pipeline_mem_pkg.sv | 17 +
 rtl/dmem_store_buffer.sv | 49 ++++
 rtl/pipeline_dmem_responder.sv | 156 +++++++++++++++
 tb/tb_pipeline_dmem_responder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mem_pkg.sv
// Shared types and constants for the M-stage data-memory responder.
package pipeline_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } dmem_state_t;

  localparam int WORD_W     = 32;
  localparam int BYTE_OFF_W = 2;

  function automatic int idx_w(input int depth_words);
    return $clog2(depth_words);
  endfunction

endpackage

// File: rtl/dmem_store_buffer.sv
// One-entry posted-store buffer: holds {idx, data}, drains on non-sample edges, forwards on a hit.
module dmem_store_buffer
  import pipeline_mem_pkg::*;
#(
  parameter int IW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              capture,
  input  logic              sample,
  input  logic [IW-1:0]     cap_idx,
  input  logic [WORD_W-1:0] cap_data,
  input  logic [IW-1:0]     look_idx,
  output logic              drain,
  output logic              hit,
  output logic [IW-1:0]     buf_idx,
  output logic [WORD_W-1:0] buf_data
);

  logic              valid_r;
  logic [IW-1:0]     idx_r;
  logic [WORD_W-1:0] data_r;

  // The sample edge reads the array, so the entry stays put (and forwards) on that edge.
  always_comb begin
    drain    = valid_r & ~sample;
    hit      = valid_r & (idx_r == look_idx);
    buf_idx  = idx_r;
    buf_data = data_r;
  end

  // Entry register: a new capture wins over the drain of the old entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= 1'b0;
      idx_r   <= {IW{1'b0}};
      data_r  <= {WORD_W{1'b0}};
    end else if (capture) begin
      valid_r <= 1'b1;
      idx_r   <= cap_idx;
      data_r  <= cap_data;
    end else if (drain) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

endmodule

// File: rtl/pipeline_dmem_responder.sv
// M-stage data-memory responder: multi-cycle loads that stall the pipeline, posted stores.
// Optional macro DMEM_FAULT_CHECK_EN drops misaligned/out-of-range accesses and pulses addrFault.
module pipeline_dmem_responder
  import pipeline_mem_pkg::*;
#(
  parameter int DEPTH_WORDS  = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [WORD_W-1:0] ALUOutM,
  input  logic [WORD_W-1:0] WriteData,
  output logic [WORD_W-1:0] ReadData,
  output logic              memStall,
  output logic              addrFault
);

  localparam int IW = idx_w(DEPTH_WORDS);
  localparam int CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [CW-1:0] CNT_LOAD  = CW'(READ_LATENCY - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic          ONE_CYCLE = (READ_LATENCY == 1);

  dmem_state_t       state_r, state_nxt_s;
  logic [CW-1:0]     cnt_r;
  logic [WORD_W-1:0] rdata_r;
  logic              fault_r;
  logic [WORD_W-1:0] mem_r [DEPTH_WORDS];

  logic [IW-1:0]     idx_s;
  logic              idle_s, addr_bad_s, load_ok_s, load_bad_s, store_ok_s, fault_s, sample_s;
  logic              drain_s, hit_s, stall_s;
  logic [IW-1:0]     buf_idx_s;
  logic [WORD_W-1:0] buf_data_s;

  assign idx_s = ALUOutM[IW+BYTE_OFF_W-1:BYTE_OFF_W];

`ifdef DMEM_FAULT_CHECK_EN
  assign addr_bad_s = (ALUOutM[BYTE_OFF_W-1:0] != 2'b00) ||
                      (ALUOutM >= WORD_W'(4 * DEPTH_WORDS));
`else
  logic unused_addr_bits_s;
  assign unused_addr_bits_s = ^{ALUOutM[WORD_W-1:IW+BYTE_OFF_W], ALUOutM[BYTE_OFF_W-1:0]};
  assign addr_bad_s         = 1'b0;
`endif

  // Request qualification; cnt_r holds the stall cycles still to come after the current one.
  always_comb begin
    idle_s     = (state_r == IDLE);
    load_ok_s  = idle_s & MemReadM & ~addr_bad_s;
    load_bad_s = idle_s & MemReadM & addr_bad_s;
    store_ok_s = idle_s & MemWriteM & ~MemReadM & ~addr_bad_s;
`ifdef DMEM_FAULT_CHECK_EN
    fault_s    = idle_s & (((MemReadM | MemWriteM) & addr_bad_s) | (MemReadM & MemWriteM));
`else
    fault_s    = 1'b0;
`endif
    sample_s   = (load_ok_s & ONE_CYCLE) | ((state_r == RD_WAIT) & (cnt_r == CNT_ONE));
  end

  dmem_store_buffer #(.IW(IW)) u_store_buffer (
    .clk      (clk),
    .reset    (reset),
    .capture  (store_ok_s),
    .sample   (sample_s),
    .cap_idx  (idx_s),
    .cap_data (WriteData),
    .look_idx (idx_s),
    .drain    (drain_s),
    .hit      (hit_s),
    .buf_idx  (buf_idx_s),
    .buf_data (buf_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (load_ok_s) begin
          state_nxt_s = ONE_CYCLE ? RD_DONE : RD_WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt_r == CNT_ONE) begin
          state_nxt_s = RD_DONE;
        end else begin
          state_nxt_s = RD_WAIT;
        end
      end
      RD_DONE: state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs; the stall is gated by reset so it drops the instant reset asserts.
  always_comb begin
    stall_s = 1'b0;
    case (state_r)
      IDLE:    stall_s = load_ok_s;
      RD_WAIT: stall_s = 1'b1;
      RD_DONE: stall_s = 1'b0;
      default: stall_s = 1'b0;
    endcase
  end

  assign memStall  = stall_s & reset;
  assign ReadData  = rdata_r;
  assign addrFault = fault_r;

  // Load wait counter, read-data register and fault pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r   <= {CW{1'b0}};
      rdata_r <= {WORD_W{1'b0}};
      fault_r <= 1'b0;
    end else begin
      fault_r <= fault_s;
      if (load_ok_s) begin
        cnt_r <= CNT_LOAD;
      end else if (state_r == RD_WAIT) begin
        cnt_r <= cnt_r - CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      if (sample_s) begin
        rdata_r <= hit_s ? buf_data_s : mem_r[idx_s];
      end else if (load_bad_s) begin
        rdata_r <= {WORD_W{1'b0}};
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Storage array, written only by store-buffer drains; contents survive reset.
  always_ff @(posedge clk) begin
    if (drain_s) begin
      mem_r[buf_idx_s] <= buf_data_s;
    end
  end

endmodule

// File: tb/tb_pipeline_dmem_responder.sv
// Self-checking bench for pipeline_dmem_responder (DEPTH_WORDS=256, READ_LATENCY=2).
// Expectations follow DMEM_FAULT_CHECK_EN when it is defined for the build.
module tb_pipeline_dmem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        MemReadM, MemWriteM;
  logic [31:0] ALUOutM, WriteData, ReadData;
  logic        memStall, addrFault;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: a store is visible to every later load; only a store not yet followed
  // by a clock edge can be lost to reset.
  logic [31:0] ref_mem [256];
  logic        pend_valid;
  logic [7:0]  pend_idx;
  logic [31:0] pend_old;

`ifdef DMEM_FAULT_CHECK_EN
  localparam bit FAULT_EN = 1'b1;
`else
  localparam bit FAULT_EN = 1'b0;
`endif

  pipeline_dmem_responder #(.DEPTH_WORDS(256), .READ_LATENCY(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .MemReadM  (MemReadM),
    .MemWriteM (MemWriteM),
    .ALUOutM   (ALUOutM),
    .WriteData (WriteData),
    .ReadData  (ReadData),
    .memStall  (memStall),
    .addrFault (addrFault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    pend_valid = 1'b0;
  endtask

  task automatic assert_reset();
    reset = 1'b0;
    if (pend_valid) ref_mem[pend_idx] = pend_old;
    pend_valid = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [31:0] data);
    logic [7:0] i;
    i = addr[9:2];
    MemWriteM = 1'b1; ALUOutM = addr; WriteData = data;
    @(negedge clk);
    n_checks++;
    if (memStall !== 1'b0) begin
      n_fail++;
      $display("FAIL store_stall addr=%h memStall=%b expected 0", addr, memStall);
    end
    tick();
    MemWriteM = 1'b0;
    pend_old = ref_mem[i]; pend_idx = i; pend_valid = 1'b1;
    ref_mem[i] = data;
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic with_store, output logic fault_seen);
    int stalls;
    stalls = 0; fault_seen = 1'b0;
    MemReadM = 1'b1; MemWriteM = with_store; ALUOutM = addr; WriteData = 32'hFFFF_0000;
    forever begin
      @(negedge clk);
      if (addrFault === 1'b1) fault_seen = 1'b1;
      if (memStall !== 1'b1) break;
      stalls++;
      if (stalls > 20) break;
      tick();
    end
    n_checks++;
    if (stalls != 2) begin
      n_fail++;
      $display("FAIL load_stall_cycles addr=%h got %0d expected 2", addr, stalls);
    end
    n_checks++;
    if (ReadData !== exp_data) begin
      n_fail++;
      $display("FAIL load_data addr=%h got %h expected %h", addr, ReadData, exp_data);
    end
    MemReadM = 1'b0; MemWriteM = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    MemReadM = 1'b0; MemWriteM = 1'b0; ALUOutM = 32'h0; WriteData = 32'h0;
    pend_valid = 1'b0;
    assert_reset();
    #2;
    n_checks++;
    if (memStall !== 1'b0 || ReadData !== 32'h0 || addrFault !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state stall=%b rdata=%h fault=%b expected 0/0/0", memStall, ReadData, addrFault);
    end
    #10 reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic f;
    do_store(32'h10, 32'hDEAD_BEEF);
    tick();
    do_load(32'h10, 32'hDEAD_BEEF, 1'b0, f);
    do_store(32'h20, 32'h0000_00AA);
    do_load(32'h20, 32'h0000_00AA, 1'b0, f);
    n_checks++;
    if (f !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_no_fault got %b expected 0", f);
    end
  endtask

  task automatic test_back_to_back();
    logic f;
    do_store(32'h8, 32'h11);
    do_store(32'hC, 32'h22);
    do_load(32'h8, 32'h11, 1'b0, f);
    do_load(32'hC, 32'h22, 1'b0, f);
    repeat (3) tick();
    n_checks++;
    if (ReadData !== 32'h22) begin
      n_fail++;
      $display("FAIL rdata_hold got %h expected %h", ReadData, 32'h22);
    end
  endtask

  task automatic test_reset_mid();
    logic f;
    MemReadM = 1'b1; ALUOutM = 32'h10;
    tick();
    assert_reset();
    #1;
    n_checks++;
    if (memStall !== 1'b0 || ReadData !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mid_load stall=%b rdata=%h expected 0/0", memStall, ReadData);
    end
    MemReadM = 1'b0;
    #3 reset = 1'b1;
    tick();
    do_store(32'h10, 32'h5555_5555);
    assert_reset();
    #3 reset = 1'b1;
    tick();
    do_load(32'h10, ref_mem[4], 1'b0, f);
    n_checks++;
    if (ReadData !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL reset_lost_store got %h expected %h", ReadData, 32'hDEAD_BEEF);
    end
  endtask

  task automatic test_fault();
    logic f;
    do_store(32'h0, 32'h1234_5678);
    do_store(32'h4, 32'h0BAD_F00D);
    tick();
    if (FAULT_EN) begin
      MemReadM = 1'b1; ALUOutM = 32'h6;
      @(negedge clk);
      n_checks++;
      if (memStall !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_load_stall got %b expected 0", memStall);
      end
      tick();
      MemReadM = 1'b0;
      n_checks++;
      if (addrFault !== 1'b1 || ReadData !== 32'h0) begin
        n_fail++;
        $display("FAIL fault_load fault=%b rdata=%h expected 1/0", addrFault, ReadData);
      end
      MemWriteM = 1'b1; ALUOutM = 32'h400; WriteData = 32'h9999_9999;
      @(negedge clk);
      n_checks++;
      if (memStall !== 1'b0 || addrFault !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_store_pre stall=%b fault=%b expected 0/0", memStall, addrFault);
      end
      tick();
      MemWriteM = 1'b0;
      n_checks++;
      if (addrFault !== 1'b1) begin
        n_fail++;
        $display("FAIL fault_store_pulse got %b expected 1", addrFault);
      end
      tick();
      n_checks++;
      if (addrFault !== 1'b0) begin
        n_fail++;
        $display("FAIL fault_pulse_width got %b expected 0", addrFault);
      end
      do_load(32'h0, ref_mem[0], 1'b0, f);
    end else begin
      do_load(32'h406, ref_mem[1], 1'b0, f);
      n_checks++;
      if (f !== 1'b0) begin
        n_fail++;
        $display("FAIL wrap_no_fault got %b expected 0", f);
      end
    end
  endtask

  task automatic test_read_write_both();
    logic f;
    do_load(32'h4, ref_mem[1], 1'b1, f);
    n_checks++;
    if (f !== FAULT_EN) begin
      n_fail++;
      $display("FAIL both_fault got %b expected %b", f, FAULT_EN);
    end
    do_load(32'h4, 32'h0BAD_F00D, 1'b0, f);
  endtask

  task automatic test_random();
    logic       f;
    logic [7:0] i;
    for (int k = 0; k < 16; k++) do_store({22'h0, k[7:0], 2'b00}, $urandom);
    for (int k = 0; k < 60; k++) begin
      i = 8'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) begin
        do_store({22'h0, i, 2'b00}, $urandom);
      end else begin
        do_load({22'h0, i, 2'b00}, ref_mem[i], 1'b0, f);
      end
      if ($urandom_range(0, 2) == 0) tick();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_reset_mid();
    test_fault();
    test_read_write_both();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
